// File: rtl/reg8file_arb.sv
// Two-requester round-robin arbiter in front of an external 8x8 register file.
// Define REG8FILE_ARB_SCRUB_EN to zero all eight registers after reset before the first grant.
module reg8file_arb (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic       rf_clr,
  output logic       rf_en,
  output logic [2:0] rf_wsel,
  output logic [2:0] rf_rsel,
  output logic [7:0] rf_d,
  input  logic [7:0] rf_q,
  output logic       busy
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       ptr_q, ptr_d;        // 0: A wins a tie, 1: B wins a tie
  logic [2:0] wsel_q, wsel_d;
  logic [2:0] rsel_q, rsel_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic       rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic       wen;
  logic       g_any, g_we;
  logic [2:0] g_addr;
  logic [7:0] g_wdata;
`ifdef REG8FILE_ARB_SCRUB_EN
  logic [2:0] scrub_cnt_q, scrub_cnt_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    ptr_d      = ptr_q;
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    wd_d       = wd_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    wen        = 1'b0;
`ifdef REG8FILE_ARB_SCRUB_EN
    scrub_cnt_d = scrub_cnt_q;
`endif

    if (state_q == ST_RUN) begin
      if (req_a && (!req_b || !ptr_q)) gnt_a = 1'b1;
      else if (req_b)                  gnt_b = 1'b1;
    end

    g_any   = gnt_a | gnt_b;
    g_we    = gnt_a ? we_a    : we_b;
    g_addr  = gnt_a ? addr_a  : addr_b;
    g_wdata = gnt_a ? wdata_a : wdata_b;

    if (g_any) begin
      ptr_d = gnt_a;
      if (g_we) begin
        wen    = 1'b1;
        wsel_d = g_addr;
        wd_d   = g_wdata;
      end else begin
        rsel_d = g_addr;
      end
    end

    if (state_q == ST_INIT) begin
`ifdef REG8FILE_ARB_SCRUB_EN
      wen         = 1'b1;
      wsel_d      = scrub_cnt_q;
      wd_d        = 8'h00;
      scrub_cnt_d = scrub_cnt_q + 3'd1;
      if (scrub_cnt_q == 3'd7) state_d = ST_RUN;
`else
      state_d = ST_RUN;
`endif
    end

    rvalid_a_d = gnt_a & ~we_a;
    rvalid_b_d = gnt_b & ~we_b;
    rdata_a_d  = rvalid_a_d ? rf_q : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? rf_q : rdata_b_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
    if (!clr_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= 1'b0;
      wsel_q     <= 3'd0;
      rsel_q     <= 3'd0;
      wd_q       <= 8'h00;
      rdata_a_q  <= 8'h00;
      rdata_b_q  <= 8'h00;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
`ifdef REG8FILE_ARB_SCRUB_EN
      scrub_cnt_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      wd_q       <= wd_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
`ifdef REG8FILE_ARB_SCRUB_EN
      scrub_cnt_q <= scrub_cnt_d;
`endif
    end
  end

  // Writes are blocked while the file is being cleared so nothing lands on top of the clear.
  assign rf_en    = wen & clr_n;
  assign rf_wsel  = wsel_d;
  assign rf_d     = wd_d;
  assign rf_rsel  = rsel_d;
  assign rf_clr   = ~clr_n;
  assign busy     = (state_q != ST_RUN);
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

endmodule

// File: doc/reg8file_arb.md
REG8FILE_ARB -- requirements
Module: reg8file_arb

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port clr_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have ports req_a / req_b, input, 1 each, access request from requester A / B.
REQ-004 SHALL have ports we_a / we_b, input, 1 each, request type: 1=write, 0=read.
REQ-005 SHALL have ports addr_a / addr_b, input, 3 each, register index 0..7.
REQ-006 SHALL have ports wdata_a / wdata_b, input, 8 each, write data.
REQ-007 SHALL have ports gnt_a / gnt_b, output, 1 each, combinational grant for the current cycle.
REQ-008 SHALL have ports rdata_a / rdata_b, output, 8 each, registered read data.
REQ-009 SHALL have ports rvalid_a / rvalid_b, output, 1 each, one-cycle pulse qualifying rdata.
REQ-010 SHALL have ports rf_clr, rf_en, output, 1 each, register-file clear (active-high) and write enable.
REQ-011 SHALL have ports rf_wsel, rf_rsel, output, 3 each, and rf_d, output, 8, register-file write/read selects and write data.
REQ-012 SHALL have port rf_q, input, 8, combinational register-file read data.
REQ-013 SHALL have port busy, output, 1, high while not in RUN state.

Function
REQ-014 SHALL implement states INIT and RUN; INIT is exited only as described in Configuration.
REQ-015 In RUN, SHALL grant at most one requester per cycle; gnt_x=1 only when req_x=1.
REQ-016 SHALL grant the sole requester immediately when only one req is high.
REQ-017 When both req are high, SHALL grant the requester not granted most recently (round-robin); the pointer favours A after reset.
REQ-018 SHALL update the round-robin pointer only on a cycle with a grant.
REQ-019 On a granted write, SHALL drive rf_en=1, rf_wsel=addr_x, rf_d=wdata_x in the same cycle; the write commits at that clk edge.
REQ-020 On a granted read, SHALL drive rf_rsel=addr_x, capture rf_q into rdata_x at that edge, and pulse rvalid_x=1 for the following cycle.
REQ-021 With no grant, SHALL drive rf_en=0; rf_wsel, rf_d, rf_rsel hold their previous values.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until granted; an ungranted request has no effect.
REQ-023 A read granted the cycle after a write to the same address SHALL return the newly written value.
REQ-024 rdata_x SHALL hold its last captured value until the next granted read by that requester.
REQ-025 Back-to-back grants to the same requester SHALL be allowed when the other requester is idle (one access per cycle sustained).
REQ-026 In INIT, SHALL force gnt_a=gnt_b=0 and busy=1.

Reset
REQ-027 While clr_n=0 at a clk edge: state=INIT, pointer=A, rdata_a=rdata_b=0, rvalid_a=rvalid_b=0, rf_en=0, rf_wsel=rf_rsel=0, rf_d=0.
REQ-028 rf_clr SHALL equal ~clr_n combinationally, so the register file clears while reset is held.
REQ-029 Reset asserted mid-operation SHALL abandon any access (a pending rvalid is suppressed) and return to INIT on that edge.

Configuration
REQ-030 Macro REG8FILE_ARB_SCRUB_EN SHALL compile in a post-reset scrub.
REQ-031 With the macro: INIT writes 8'h00 to registers 0..7 in order, one per cycle (rf_en=1, rf_wsel=counter), then enters RUN; busy is high for exactly 8 cycles after clr_n rises.
REQ-032 Without the macro: INIT lasts one cycle after clr_n rises, then the block enters RUN; there is no scrub counter.

Verification
REQ-033 Reset, then req_a write addr 3 data 8'hA5 -> gnt_a=1 same cycle, rf_en=1, rf_wsel=3, rf_d=8'hA5.
REQ-034 Write 8'h5A to addr 6 via A, then read addr 6 via B the next cycle -> rvalid_b pulses one cycle later, rdata_b=8'h5A.
REQ-035 req_a and req_b held high for 4 cycles -> grant sequence A,B,A,B.
REQ-036 With REG8FILE_ARB_SCRUB_EN, release reset -> busy=1 for 8 cycles, rf_wsel counts 0..7 with rf_d=0, and no grant during INIT.
REQ-037 Assert clr_n=0 in the cycle a read is granted -> no rvalid pulse, rdata=0, rf_clr=1.
